// File: rtl/cmp_pkg.sv
// Shared types for the sequential magnitude comparator: relation encoding,
// FSM state encoding and the relation evaluation helper.
package cmp_pkg;

    typedef enum logic [1:0] {
        OP_LT = 2'd0,
        OP_LE = 2'd1,
        OP_EQ = 2'd2,
        OP_GT = 2'd3
    } cmp_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } cmp_state_e;

    // Map the resolved lt/eq pair onto the requested relation.
    function automatic logic eval_op(input cmp_op_e op, input logic lt, input logic eq);
        logic gt;
        gt = ~lt & ~eq;
        case (op)
            OP_LT:   eval_op = lt;
            OP_LE:   eval_op = lt | eq;
            OP_EQ:   eval_op = eq;
            default: eval_op = gt;
        endcase
    endfunction

endpackage

// File: rtl/cmp_digit.sv
// Combinational unsigned compare of one DIGIT-bit slice.
module cmp_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    output logic             lt_o,
    output logic             eq_o
);

    // Slice relation; gt is implied by ~lt & ~eq.
    always_comb begin
        lt_o = (a_i < b_i);
        eq_o = (a_i == b_i);
    end

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Digit-serial magnitude comparator. Operands are latched once, then scanned
// MSB-first one DIGIT-bit slice per cycle; the first differing slice decides.
//
// Handshake: a request transfers on a rising edge where in_valid & in_ready;
// a result transfers on a rising edge where out_valid & out_ready. Each
// side's valid may rise without waiting for ready; once out_valid is high,
// result and out_digits hold until the transfer.
module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4,
    localparam int N    = WIDTH / DIGIT,
    localparam int CW   = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             result,
    output logic [CW-1:0]    out_digits,
    output cmp_state_e       dbg_state
);

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("WIDTH must be a multiple of DIGIT");
    end

    cmp_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    cmp_op_e          op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             result_q, result_d;

    logic             accept;
    logic             slice_lt;
    logic             slice_eq;
    logic             last_digit;

    // Top slice of the shifting operand registers feeds the digit compare.
    cmp_digit #(.DIGIT(DIGIT)) u_digit (
        .a_i  (a_q[WIDTH-1 -: DIGIT]),
        .b_i  (b_q[WIDTH-1 -: DIGIT]),
        .lt_o (slice_lt),
        .eq_o (slice_eq)
    );

    assign accept     = in_valid & in_ready;
    assign last_digit = (cnt_q == CW'(N - 1));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: leave SCAN on the first differing slice or the last one.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_SCAN;
            ST_SCAN: if (!slice_eq || last_digit) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: in_ready  = 1'b1;
            ST_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath next state: latch with sign bias, then shift one slice per scan cycle.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    // Flipping the sign bit maps two's-complement order onto unsigned order.
                    a_d   = a ^ {is_signed, {(WIDTH-1){1'b0}}};
                    b_d   = b ^ {is_signed, {(WIDTH-1){1'b0}}};
                    op_d  = cmp_op_e'(op);
                    cnt_d = '0;
                end
            end
            ST_SCAN: begin
                cnt_d = cnt_q + CW'(1);
                a_d   = a_q << DIGIT;
                b_d   = b_q << DIGIT;
                if (!slice_eq || last_digit) begin
                    result_d = eval_op(op_q, slice_lt, slice_eq);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_LT;
            cnt_q    <= '0;
            result_q <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign result     = result_q;
    assign out_digits = cnt_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed bench for seq_magnitude_comparator (WIDTH=32, DIGIT=4).
module tb_seq_magnitude_comparator;
    import cmp_pkg::*;

    localparam int WIDTH = 32;
    localparam int DIGIT = 4;
    localparam int N     = WIDTH / DIGIT;
    localparam int CW    = $clog2(N + 1);

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             is_signed;
    logic             out_valid;
    logic             out_ready;
    logic             result;
    logic [CW-1:0]    out_digits;
    cmp_state_e       dbg_state;

    int n_checks = 0;
    int n_passed = 0;

    seq_magnitude_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .op         (op),
        .is_signed  (is_signed),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .out_digits (out_digits),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Drive one request; returns the number of edges from accept to out_valid (0 on timeout).
    task automatic send_and_wait(input logic [31:0] av, input logic [31:0] bv,
                                 input logic [1:0] opv, input logic sv, output int lat);
        @(negedge clk);
        in_valid  = 1'b1;
        a         = av;
        b         = bv;
        op        = opv;
        is_signed = sv;
        @(posedge clk);
        #1;
        // Junk on the inputs after accept must be ignored.
        in_valid  = 1'b0;
        a         = $urandom;
        b         = $urandom;
        op        = 2'($urandom_range(0, 3));
        is_signed = 1'($urandom_range(0, 1));
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
    endtask

    task automatic run_case(input string tag, input logic [31:0] av, input logic [31:0] bv,
                            input logic [1:0] opv, input logic sv,
                            input logic exp_res, input int exp_dig);
        int lat;
        send_and_wait(av, bv, opv, sv, lat);
        check({tag, "_latency"}, 32'(lat), 32'(exp_dig));
        if (lat != 0) begin
            check({tag, "_result"}, 32'(result), 32'(exp_res));
            check({tag, "_digits"}, 32'(out_digits), 32'(exp_dig));
            handshake(tag);
        end
    endtask

    initial begin
        logic          hold_res;
        logic [CW-1:0] hold_dig;
        int            lat;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = 2'd0;
        is_signed = 1'b0;
        out_ready = 1'b0;

        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_digits", 32'(out_digits), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1;

        // Hand-computed vectors: first differing nibble gives the digit count.
        run_case("lt_small",   32'h0000_0005, 32'h0000_0007, 2'd0, 1'b0, 1'b1, 8);
        run_case("lt_signed",  32'h8000_0000, 32'h0000_0001, 2'd0, 1'b1, 1'b1, 1);
        run_case("lt_unsign",  32'h8000_0000, 32'h0000_0001, 2'd0, 1'b0, 1'b0, 1);
        run_case("eq_lt",      32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'd0, 1'b0, 1'b0, 8);
        run_case("eq_le",      32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'd1, 1'b0, 1'b1, 8);
        run_case("eq_eq",      32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'd2, 1'b0, 1'b1, 8);
        run_case("eq_gt",      32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'd3, 1'b0, 1'b0, 8);
        run_case("gt_unsign",  32'hFFFF_FFFF, 32'h0000_0000, 2'd3, 1'b0, 1'b1, 1);
        run_case("gt_signed",  32'hFFFF_FFFF, 32'h0000_0000, 2'd3, 1'b1, 1'b0, 1);
        run_case("le_mid",     32'h1234_5678, 32'h1239_0000, 2'd1, 1'b0, 1'b1, 4);
        run_case("eq_neq",     32'h1234_5678, 32'h1234_5679, 2'd2, 1'b0, 1'b0, 8);
        run_case("gt_neg",     32'hFFFF_FFFE, 32'hFFFF_FFF0, 2'd3, 1'b1, 1'b1, 8);

        // Back-pressure: result held while out_ready is low.
        send_and_wait(32'h0010_0000, 32'h0020_0000, 2'd0, 1'b0, lat);
        check("bp_latency", 32'(lat), 32'd3);
        hold_res = 1'b1;
        hold_dig = CW'(3);
        for (int i = 0; i < 5; i++) begin
            check("bp_result", 32'(result), 32'(hold_res));
            check("bp_digits", 32'(out_digits), 32'(hold_dig));
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        handshake("bp");

        // Reset in the middle of a scan aborts it.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 32'h0000_0001;
        b        = 32'h0000_0001;
        op       = 2'd2;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) @(posedge clk);
        #2;
        check("mid_state_scan", 32'(dbg_state), 32'(ST_SCAN));
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_digits", 32'(out_digits), 32'd0);
        check("arst_result", 32'(result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_case("post_rst_gt", 32'h0000_0003, 32'h0000_0002, 2'd3, 1'b0, 1'b1, 8);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_magnitude_comparator.md
SEQ_MAGNITUDE_COMPARATOR -- requirements
Module: seq_magnitude_comparator

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits.
REQ-002 SHALL have parameter DIGIT, default 4: bits compared per cycle; WIDTH % DIGIT == 0, else elaboration error.
REQ-003 SHALL use the derived constant N = WIDTH/DIGIT for the number of digits, and CW = clog2(N+1) for the digit-count width.
REQ-004 SHALL have port clk  input  1  single clock; all state on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port in_valid  input  1  operand request valid.
REQ-007 SHALL have port in_ready  output  1  block can accept a request.
REQ-008 SHALL have port a  input  WIDTH  left operand.
REQ-009 SHALL have port b  input  WIDTH  right operand.
REQ-010 SHALL have port op  input  2  relation: 0=LT, 1=LE, 2=EQ, 3=GT.
REQ-011 SHALL have port is_signed  input  1  1 = two's-complement compare, 0 = unsigned.
REQ-012 SHALL have port out_valid  output  1  result valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts result.
REQ-014 SHALL have port result  output  1  (a op b) under the latched signedness.
REQ-015 SHALL have port out_digits  output  CW  number of digits scanned, 1..N.

Function
REQ-016 SHALL implement FSM states IDLE, SCAN and DONE.
REQ-017 SHALL drive in_ready = 1 only in IDLE.
REQ-018 SHALL drive out_valid = 1 only in DONE.
REQ-019 SHALL, on accept (in_valid & in_ready), latch a, b, op and is_signed, clear the digit index and the counter, and go IDLE -> SCAN.
REQ-020 SHALL, when is_signed is latched as 1, invert bit WIDTH-1 of both latched operands, then compare unsigned.
REQ-021 SHALL, in SCAN, compare one DIGIT-bit slice per cycle, MSB-first, and increment out_digits each scan cycle.
REQ-022 SHALL, when slices differ, resolve lt/gt from that slice and go SCAN -> DONE on that edge (early termination).
REQ-023 SHALL, when the slices are equal on digit N, resolve eq and go SCAN -> DONE.
REQ-024 SHALL raise out_valid k edges after the accept edge, where k = 1-based index of the first differing digit, or N if the operands are equal.
REQ-025 SHALL compute result as LT = lt, LE = lt|eq, EQ = eq, GT = gt.
REQ-026 SHALL hold result and out_digits stable while out_valid & ~out_ready.
REQ-027 SHALL, on out_valid & out_ready, go DONE -> IDLE, with in_ready = 1 on the next cycle; there is no same-cycle re-accept.
REQ-028 SHALL ignore in_valid, a, b, op and is_signed outside IDLE.
REQ-029 SHALL not require in_valid to be held after accept.
REQ-030 SHALL, with DIGIT == WIDTH (N = 1), always decide in exactly 1 scan cycle.

Reset
REQ-031 SHALL, when rst_n = 0, immediately force: state IDLE, in_ready 1, out_valid 0, result 0, out_digits 0, operand registers 0.
REQ-032 SHALL, on reset during SCAN or DONE, abort the operation and discard the result, with no residual effect after release.
REQ-033 SHALL accept a request on the first rising edge with rst_n = 1.

Structure
REQ-034 SHALL define the op encoding (cmp_op_e) and the FSM state enum (cmp_state_e) in the shared package cmp_pkg.
REQ-035 SHALL instantiate one combinational sub-module cmp_digit (DIGIT-bit inputs; lt and eq outputs) for the slice compare.
REQ-036 SHALL select the slice by shifting the operand registers, with no WIDTH-wide comparator.

Verification (WIDTH=32, DIGIT=4, N=8)
REQ-037 SHALL cover: a=0x00000005, b=0x00000007, LT, unsigned -> result 1, out_digits 8, out_valid 8 edges after accept.
REQ-038 SHALL cover: a=0x80000000, b=0x00000001, LT -> signed: result 1, out_digits 1; unsigned: result 0, out_digits 1.
REQ-039 SHALL cover: a=b=0xDEADBEEF -> LT 0, LE 1, EQ 1, GT 0, each with out_digits 8.
REQ-040 SHALL cover: a=0xFFFFFFFF, b=0, GT -> unsigned 1, signed 0, out_digits 1.
REQ-041 SHALL cover: out_ready held 0 for 5 cycles in DONE -> result and out_digits stable, in_ready 0; after the handshake, in_ready 1 on the next cycle.
REQ-042 SHALL cover: rst_n pulsed low at scan cycle 3 -> out_valid 0 and in_ready 1 asynchronously; a following a=3, b=2, GT request -> result 1, out_digits 8.
